// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Purpose  : Shared op encodings and queued request type for the MD dispatch.
//  Revision : 1.0  initial release
// ============================================================================
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    // Ops 6 and 7 are not HI/LO writers and must never occupy a slot.
    function automatic logic md_op_legal(input logic [2:0] op);
        return op <= MD_MTLO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module   : md_dispatch_if
//  Purpose  : Pipeline request / read-stall / MD-unit bundle for md_dispatch.
//  Revision : 1.0  initial release
// ============================================================================
interface md_dispatch_if #(
    parameter int DEPTH = 2
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic          rd_req;
    logic          rd_stall;
    logic          md_busy;
    logic [31:0]   md_in1;
    logic [31:0]   md_in2;
    logic [2:0]    md_op;
    logic          md_chose;
    logic          md_change_hi;
    logic          md_change_lo;
    logic [PW-1:0] pending;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rd_req, md_busy,
        output req_ready, rd_stall, md_in1, md_in2, md_op,
               md_chose, md_change_hi, md_change_lo, pending
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rd_req, md_busy,
        input  req_ready, rd_stall, md_in1, md_in2, md_op,
               md_chose, md_change_hi, md_change_lo, pending
    );

endinterface
`default_nettype wire

// File: rtl/md_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : md_req_fifo
//  Purpose  : Synchronous FIFO of md_req_t with async clear and occupancy.
//  Revision : 1.0  initial release
// ============================================================================
module md_req_fifo
    import md_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    input  wire logic    push,
    input  wire md_req_t wdata,
    input  wire logic    pop,
    output md_req_t      rdata,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    md_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/md_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : md_dispatch
//  Purpose  : In-order HI/LO writer queue feeding the multiply/divide unit,
//             plus the mfhi/mflo read stall.
//  Revision : 1.0  initial release
// ============================================================================
module md_dispatch
    import md_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    md_dispatch_if.slave  bus
);

    localparam int PW = $clog2(DEPTH) + 1;

    md_req_t       req;
    md_req_t       head;
    logic          push;
    logic          issue;
    logic          full;
    logic          empty;
    logic [PW-1:0] count;

    assign req   = '{op: bus.req_op, a: bus.req_a, b: bus.req_b};
    assign push  = bus.req_valid & ~full & md_op_legal(bus.req_op);
    // Reset gating keeps every unit-facing strobe quiet during a mid-cycle clear.
    assign issue = ~empty & ~bus.md_busy & ~reset;

    md_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (req),
        .pop   (issue),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        bus.md_chose     = 1'b0;
        bus.md_change_hi = 1'b0;
        bus.md_change_lo = 1'b0;
        bus.md_in1       = '0;
        bus.md_in2       = '0;
        bus.md_op        = '0;
        if (issue) begin
            bus.md_in1 = head.a;
            case (head.op)
                MD_MTHI: bus.md_change_hi = 1'b1;
                MD_MTLO: bus.md_change_lo = 1'b1;
                default: begin
                    bus.md_chose = 1'b1;
                    bus.md_op    = {1'b0, head.op[1:0]};
                    bus.md_in2   = head.b;
                end
            endcase
        end
    end

    assign bus.req_ready = ~full;
    assign bus.pending   = count;
    assign bus.rd_stall  = ~reset & bus.rd_req & (~empty | bus.md_busy);

endmodule
`default_nettype wire
